// File: rtl/parking_occupancy_accumulator.sv
// parking_occupancy_accumulator
//   Registered lot-occupancy tracker. Each clock it applies a batched exit
//   and then a batched entry to the current occupancy. Each batch is range
//   checked against CAPACITY and is accepted or rejected as a whole.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset (wins over all inputs)
//   enter_valid    enter batch present this cycle
//   enter_count    cars entering (only looked at when enter_valid=1)
//   exit_valid     exit batch present this cycle
//   exit_count     cars leaving (only looked at when exit_valid=1)
//   clear_err      clears the sticky error flags at the next edge
//   occupancy      occupied slots
//   free_slots     CAPACITY - occupancy
//   full / empty   occupancy == CAPACITY / occupancy == 0
//   enter_ack / enter_reject / exit_ack / exit_reject
//                  one-cycle result pulses for the batches of the last cycle
//   err_overflow   sticky, set by any enter_reject
//   err_underflow  sticky, set by any exit_reject
module parking_occupancy_accumulator #(
  parameter int WIDTH    = 3,
  parameter int STEP_W   = 3,
  parameter int CAPACITY = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter_valid,
  input  logic [STEP_W-1:0] enter_count,
  input  logic              exit_valid,
  input  logic [STEP_W-1:0] exit_count,
  input  logic              clear_err,
  output logic [WIDTH-1:0]  occupancy,
  output logic [WIDTH-1:0]  free_slots,
  output logic              full,
  output logic              empty,
  output logic              enter_ack,
  output logic              enter_reject,
  output logic              exit_ack,
  output logic              exit_reject,
  output logic              err_overflow,
  output logic              err_underflow
);

  // One extra bit over the wider operand, so no sum or compare can wrap.
  localparam int SUM_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  generate
    if (CAPACITY < 1 || CAPACITY > (2 ** WIDTH) - 1) begin : g_bad_capacity
      $error("parking_occupancy_accumulator: CAPACITY must be in 1..2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             enter_ack_q, enter_ack_d;
  logic             enter_reject_q, enter_reject_d;
  logic             exit_ack_q, exit_ack_d;
  logic             exit_reject_q, exit_reject_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_underflow_q, err_underflow_d;

  logic [SUM_W-1:0] occ_s, enter_s, exit_s, mid_s, room_s, next_s;
  logic             exit_ok, enter_ok;

  always_comb begin
    occ_s   = SUM_W'(occ_q);
    // A non-valid batch behaves as a zero count; its ack/reject is masked below.
    enter_s = enter_valid ? SUM_W'(enter_count) : '0;
    exit_s  = exit_valid  ? SUM_W'(exit_count)  : '0;

    // Exit is applied first so that cars leaving make room for cars entering
    // in the same cycle.
    exit_ok  = (exit_s <= occ_s);
    mid_s    = exit_ok ? (occ_s - exit_s) : occ_s;
    room_s   = CAP_S - mid_s;
    enter_ok = (enter_s <= room_s);
    next_s   = enter_ok ? (mid_s + enter_s) : mid_s;

    occ_d   = WIDTH'(next_s);
    free_d  = WIDTH'(CAP_S - next_s);
    full_d  = (next_s == CAP_S);
    empty_d = (next_s == '0);

    enter_ack_d    = enter_valid &&  enter_ok;
    enter_reject_d = enter_valid && !enter_ok;
    exit_ack_d     = exit_valid  &&  exit_ok;
    exit_reject_d  = exit_valid  && !exit_ok;

    // A fresh reject outranks clear_err.
    err_overflow_d  = (err_overflow_q  && !clear_err) || enter_reject_d;
    err_underflow_d = (err_underflow_q && !clear_err) || exit_reject_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q           <= '0;
      free_q          <= WIDTH'(CAPACITY);
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      enter_ack_q     <= 1'b0;
      enter_reject_q  <= 1'b0;
      exit_ack_q      <= 1'b0;
      exit_reject_q   <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      free_q          <= free_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      enter_ack_q     <= enter_ack_d;
      enter_reject_q  <= enter_reject_d;
      exit_ack_q      <= exit_ack_d;
      exit_reject_q   <= exit_reject_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign occupancy     = occ_q;
  assign free_slots    = free_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign enter_ack     = enter_ack_q;
  assign enter_reject  = enter_reject_q;
  assign exit_ack      = exit_ack_q;
  assign exit_reject   = exit_reject_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_parking_occupancy_accumulator.sv
// Testbench for parking_occupancy_accumulator (default parameters).
// Each driven cycle pushes the reference model's expected outputs onto a
// queue; the scenario task pops the entry once the DUT has updated and
// compares it against the sampled outputs.
module tb_parking_occupancy_accumulator;

  localparam int CAP = 6;

  typedef struct packed {
    logic [2:0] occ;
    logic [2:0] free;
    logic       full;
    logic       empty;
    logic       eack;
    logic       erej;
    logic       xack;
    logic       xrej;
    logic       eovf;
    logic       eunf;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       ev;
    logic [2:0] ec;
    logic       xv;
    logic [2:0] xc;
    logic       clr;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter_valid = 1'b0;
  logic [2:0] enter_count = '0;
  logic       exit_valid = 1'b0;
  logic [2:0] exit_count = '0;
  logic       clear_err = 1'b0;
  logic [2:0] occupancy, free_slots;
  logic       full, empty, enter_ack, enter_reject, exit_ack, exit_reject;
  logic       err_overflow, err_underflow;

  int errors = 0;
  int checks = 0;

  out_t exp_q[$];

  // reference model state
  int  m_occ = 0;
  logic m_eovf = 1'b0, m_eunf = 1'b0;

  parking_occupancy_accumulator #(.WIDTH(3), .STEP_W(3), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset),
    .enter_valid(enter_valid), .enter_count(enter_count),
    .exit_valid(exit_valid), .exit_count(exit_count),
    .clear_err(clear_err),
    .occupancy(occupancy), .free_slots(free_slots),
    .full(full), .empty(empty),
    .enter_ack(enter_ack), .enter_reject(enter_reject),
    .exit_ack(exit_ack), .exit_reject(exit_reject),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.occ  = occupancy;   o.free = free_slots;
    o.full = full;        o.empty = empty;
    o.eack = enter_ack;   o.erej = enter_reject;
    o.xack = exit_ack;    o.xrej = exit_reject;
    o.eovf = err_overflow; o.eunf = err_underflow;
    return o;
  endfunction

  function automatic stim_t mk(logic rst, logic ev, int ec, logic xv, int xc, logic clr);
    stim_t s;
    s.rst = rst; s.ev = ev; s.ec = 3'(ec); s.xv = xv; s.xc = 3'(xc); s.clr = clr;
    return s;
  endfunction

  // Drives one cycle, pushes the model's prediction, returns #1 after the edge.
  task automatic step(input stim_t s);
    out_t e;
    int   mid;
    logic xa, ea;
    @(negedge clk);
    reset = s.rst; enter_valid = s.ev; enter_count = s.ec;
    exit_valid = s.xv; exit_count = s.xc; clear_err = s.clr;
    e = '0;
    if (s.rst) begin
      m_occ = 0; m_eovf = 1'b0; m_eunf = 1'b0;
    end else begin
      xa  = s.xv && (int'(s.xc) <= m_occ);
      mid = xa ? m_occ - int'(s.xc) : m_occ;
      ea  = s.ev && (int'(s.ec) <= CAP - mid);
      m_occ  = ea ? mid + int'(s.ec) : mid;
      e.eack = ea;          e.erej = s.ev && !ea;
      e.xack = xa;          e.xrej = s.xv && !xa;
      m_eovf = (m_eovf && !s.clr) || e.erej;
      m_eunf = (m_eunf && !s.clr) || e.xrej;
    end
    e.occ   = 3'(m_occ);
    e.free  = 3'(CAP - m_occ);
    e.full  = (m_occ == CAP);
    e.empty = (m_occ == 0);
    e.eovf  = m_eovf;
    e.eunf  = m_eunf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, o;
    step(mk(1, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_model: got %h expected %h", o, e); end
    checks++;
    if (o !== 16'b000_110_0_1_0000_0_0) begin
      errors++; $display("FAIL reset_values: got %h expected %h", o, 16'b000_110_0_1_0000_0_0);
    end
    step(mk(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_idle: got %h expected %h", o, e); end
  endtask

  task automatic test_fill_overflow();
    stim_t st[3];
    out_t e, o;
    st[0] = mk(0, 1, 3, 0, 0, 0);
    st[1] = mk(0, 1, 3, 0, 0, 0);
    st[2] = mk(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(st[i]);
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) begin errors++; $display("FAIL fill_overflow row %0d: got %h expected %h", i, o, e); end
      if (i == 1) begin
        checks++;
        if ({occupancy, full, free_slots, enter_ack} !== {3'd6, 1'b1, 3'd0, 1'b1}) begin
          errors++; $display("FAIL fill_full: got occ=%0d full=%b free=%0d ack=%b expected 6 1 0 1",
                             occupancy, full, free_slots, enter_ack);
        end
      end
      if (i == 2) begin
        checks++;
        if ({occupancy, enter_reject, err_overflow, enter_ack} !== {3'd6, 1'b1, 1'b1, 1'b0}) begin
          errors++; $display("FAIL overflow_reject: got occ=%0d rej=%b ovf=%b ack=%b expected 6 1 1 0",
                             occupancy, enter_reject, err_overflow, enter_ack);
        end
      end
    end
  endtask

  task automatic test_simultaneous_full();
    out_t e, o;
    step(mk(0, 1, 2, 1, 2, 1));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL simul_full_model: got %h expected %h", o, e); end
    checks++;
    if ({exit_ack, enter_ack, occupancy, enter_reject, exit_reject, full} !== {1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL simul_full: got xack=%b eack=%b occ=%0d erej=%b xrej=%b full=%b expected 1 1 6 0 0 1",
                         exit_ack, enter_ack, occupancy, enter_reject, exit_reject, full);
    end
  endtask

  task automatic test_partial_underflow();
    stim_t st[2];
    out_t e, o;
    st[0] = mk(0, 0, 0, 1, 5, 0);
    st[1] = mk(0, 1, 1, 1, 2, 0);
    for (int i = 0; i < 2; i++) begin
      step(st[i]);
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) begin errors++; $display("FAIL partial_underflow row %0d: got %h expected %h", i, o, e); end
    end
    checks++;
    if ({exit_reject, err_underflow, enter_ack, occupancy} !== {1'b1, 1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL partial_underflow: got xrej=%b unf=%b eack=%b occ=%0d expected 1 1 1 2",
                         exit_reject, err_underflow, enter_ack, occupancy);
    end
  endtask

  task automatic test_clear_err();
    out_t e, o;
    step(mk(0, 0, 0, 1, 5, 1));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL clear_with_reject_model: got %h expected %h", o, e); end
    checks++;
    if ({exit_reject, err_underflow, occupancy} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL clear_set_wins: got xrej=%b unf=%b occ=%0d expected 1 1 2",
                         exit_reject, err_underflow, occupancy);
    end
    step(mk(0, 0, 0, 0, 0, 1));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL clear_alone_model: got %h expected %h", o, e); end
    checks++;
    if ({err_underflow, err_overflow, exit_reject, exit_ack} !== 4'b0000) begin
      errors++; $display("FAIL clear_alone: got unf=%b ovf=%b xrej=%b xack=%b expected 0 0 0 0",
                         err_underflow, err_overflow, exit_reject, exit_ack);
    end
  endtask

  task automatic test_reset_midstream();
    out_t e, o;
    step(mk(0, 1, 3, 0, 0, 0));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e || occupancy !== 3'd5) begin
      errors++; $display("FAIL midstream_setup: got %h expected %h (occ 5)", o, e);
    end
    step(mk(1, 1, 1, 0, 0, 0));
    e = exp_q.pop_front(); o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL midstream_reset_model: got %h expected %h", o, e); end
    checks++;
    if ({occupancy, enter_ack, enter_reject, empty, free_slots} !== {3'd0, 1'b0, 1'b0, 1'b1, 3'd6}) begin
      errors++; $display("FAIL midstream_reset: got occ=%0d eack=%b erej=%b empty=%b free=%0d expected 0 0 0 1 6",
                         occupancy, enter_ack, enter_reject, empty, free_slots);
    end
  endtask

  task automatic test_zero_count();
    stim_t st[3];
    out_t e, o;
    st[0] = mk(0, 1, 0, 1, 0, 0);
    st[1] = mk(0, 1, 6, 0, 0, 0);
    st[2] = mk(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(st[i]);
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) begin errors++; $display("FAIL zero_count row %0d: got %h expected %h", i, o, e); end
      if (i != 1) begin
        checks++;
        if ({enter_ack, exit_ack, enter_reject, exit_reject} !== 4'b1100) begin
          errors++; $display("FAIL zero_count_ack row %0d: got eack=%b xack=%b erej=%b xrej=%b expected 1 1 0 0",
                             i, enter_ack, exit_ack, enter_reject, exit_reject);
        end
      end
    end
    checks++;
    if (occupancy !== 3'd6) begin
      errors++; $display("FAIL zero_count_occ: got %0d expected 6", occupancy);
    end
  endtask

  task automatic test_random_traffic();
    out_t e, o;
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 9) == 0));
      step(s);
      e = exp_q.pop_front(); o = sample();
      checks++;
      if (o !== e) begin errors++; $display("FAIL random row %0d: got %h expected %h", i, o, e); end
      checks++;
      if (int'(occupancy) > CAP) begin
        errors++; $display("FAIL random_bound row %0d: got occ=%0d expected <= %0d", i, occupancy, CAP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_simultaneous_full();
    test_partial_underflow();
    test_clear_err();
    test_reset_midstream();
    test_zero_count();
    test_random_traffic();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_accumulator.md
Name: parking_occupancy_accumulator

Overview:
- Parametrised, registered successor to the 3-bit combinational adder/subtractor.
- Tracks lot occupancy by adding batched entries and subtracting batched exits every clock.
- Range-checks each operation against a configurable capacity, accepting or rejecting it.
- Drives full/empty/free-slot outputs to the display and gate controllers, plus sticky overflow/underflow error flags.

Parameters:
- WIDTH, 3, occupancy/free-slot register width.
- STEP_W, 3, width of the per-cycle enter/exit batch counts.
- CAPACITY, 6, maximum legal occupancy. Must satisfy 1 ≤ CAPACITY ≤ 2^WIDTH−1; violation is an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enter_valid  input  1  enter batch request this cycle.
- enter_count  input  STEP_W  cars entering; sampled only when enter_valid=1.
- exit_valid  input  1  exit batch request this cycle.
- exit_count  input  STEP_W  cars leaving; sampled only when exit_valid=1.
- clear_err  input  1  clears sticky error flags.
- occupancy  output  WIDTH  current occupied slots.
- free_slots  output  WIDTH  CAPACITY − occupancy.
- full  output  1  occupancy == CAPACITY.
- empty  output  1  occupancy == 0.
- enter_ack  output  1  one-cycle pulse: enter batch accepted.
- enter_reject  output  1  one-cycle pulse: enter batch refused.
- exit_ack  output  1  one-cycle pulse: exit batch accepted.
- exit_reject  output  1  one-cycle pulse: exit batch refused.
- err_overflow  output  1  sticky: an enter batch was refused.
- err_underflow  output  1  sticky: an exit batch was refused.

Behaviour:
- Reset: one clock with reset=1 sets occupancy=0, free_slots=CAPACITY, empty=1, full=0, all ack/reject pulses=0, err_overflow=0, err_underflow=0.
- Reset has priority over every other input in the same cycle. Requests presented during reset are discarded and produce no ack/reject.
- Latency: requests sampled at edge N. At that same edge, occupancy, flags and ack/reject update, so all are visible in cycle N+1. No backpressure; a request is valid for exactly one cycle.
- Evaluation order each cycle (exit first, so simultaneous traffic never falsely overflows):
  - Exit accepted iff exit_count ≤ occupancy. Set occ_mid = occupancy − exit_count if accepted, else occupancy.
  - Enter accepted iff enter_count ≤ CAPACITY − occ_mid. Next occupancy = occ_mid + enter_count if accepted, else occ_mid.
- Arithmetic: intermediate sums are computed at max(WIDTH, STEP_W)+1 bits, zero-extended, with no wrap-around. A rejected operation leaves occupancy unchanged by that operation.
- Zero-count request: valid with count 0 is always accepted and produces an ack with no change.
- Each valid input yields exactly one of ack/reject. With valid=0, both ack and reject are 0.
- full, empty and free_slots are registered and consistent with the occupancy value of the same cycle.
- Sticky errors:
  - enter_reject sets err_overflow; exit_reject sets err_underflow.
  - clear_err=1 clears both flags at the next edge.
  - If a new reject occurs in the same cycle as clear_err, set wins and the flag stays 1.
- Invariant: occupancy never exceeds CAPACITY and never wraps below 0.

Test Plan:
- Reset (defaults WIDTH=3, STEP_W=3, CAPACITY=6) → occupancy=0, free_slots=6, empty=1, full=0, all flags 0.
- Fill and overflow:
  - enter 3, then enter 3 → two enter_ack pulses; occupancy=6, full=1, free_slots=0.
  - Then enter 1 → enter_reject=1, err_overflow=1, occupancy stays 6.
- Simultaneous at full: occupancy=6, exit 2 and enter 2 in the same cycle → exit_ack=1, enter_ack=1, occupancy=6, no error.
- Partial underflow: occupancy=1, exit 2 and enter 1 in the same cycle → exit_reject=1, err_underflow=1, enter_ack=1, occupancy=2.
- Error clearing:
  - clear_err together with an exit 5 at occupancy 2 → exit_reject, err_underflow remains 1.
  - Next cycle, clear_err alone → err_underflow=0 and err_overflow=0.
- Reset mid-stream: occupancy=5, reset=1 with enter_valid=1 and count 1 → occupancy=0, enter_ack=0, enter_reject=0, empty=1.
